// File: rtl/evil_bullet_pool_if.sv
// Control/status bundle between GameControl and the enemy bullet pool.
// The game side drives the master modport; the pool sits on the slave modport.
interface evil_bullet_pool_if #(
  parameter int N = 4
);
  logic                tick;
  logic                attack;
  logic signed [10:0]  xEnemy;
  logic signed [9:0]   yEnemy;
  logic signed [10:0]  xPlayer;
  logic signed [9:0]   yPlayer;
  logic                isQ;
  logic                defend;
  logic [N*11-1:0]     bx;
  logic [N*10-1:0]     by;
  logic [N-1:0]        bvalid;
  logic                isHit;
  logic                isBlock;

  modport master (
    output tick, attack, xEnemy, yEnemy, xPlayer, yPlayer, isQ, defend,
    input  bx, by, bvalid, isHit, isBlock
  );

  modport slave (
    input  tick, attack, xEnemy, yEnemy, xPlayer, yPlayer, isQ, defend,
    output bx, by, bvalid, isHit, isBlock
  );
endinterface

// File: rtl/evil_bullet_pool.sv
// Enemy projectile pool: spawns at the enemy muzzle under a cooldown, flies in -x,
// and resolves each bullet against the player hitbox as a hit or a block.
module evil_bullet_pool #(
  parameter int N        = 4,
  parameter int STEP_X   = 4,
  parameter int BULLET_X = 4,
  parameter int BULLET_Y = 4,
  parameter int PLAYER_X = 16,
  parameter int PLAYER_Y = 32,
  parameter int SQUAT_DY = 24,
  parameter int COOLDOWN = 15,
  parameter int MAP_X    = 640
) (
  input  logic              clk,
  input  logic              rst,
  evil_bullet_pool_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic signed [12:0] STEP13    = 13'(STEP_X);
  localparam logic signed [12:0] BX13      = 13'(BULLET_X);
  localparam logic signed [12:0] BY13      = 13'(BULLET_Y);
  localparam logic signed [12:0] PX13      = 13'(PLAYER_X);
  localparam logic signed [12:0] PY13      = 13'(PLAYER_Y);
  localparam logic signed [12:0] SQ13      = 13'(SQUAT_DY);
  localparam logic signed [12:0] SPAWN_MAX = 13'(MAP_X - BULLET_X);

  slot_state_t        state [N];
  logic signed [10:0] x_q   [N];
  logic signed [9:0]  y_q   [N];
  logic [CW-1:0]      cnt;
  logic               hit_q;
  logic               block_q;

  // Per-slot next position and collision terms, all in 13-bit signed so nothing wraps.
  logic signed [12:0] xn       [N];
  logic               col      [N];
  logic               off_left [N];
  logic               col_any;
  logic signed [12:0] ply_l, ply_r, ply_top, ply_bot;

  always_comb begin
    ply_l   = 13'(bus.xPlayer) - PX13;
    ply_r   = 13'(bus.xPlayer) + PX13;
    ply_top = 13'(bus.yPlayer) - PY13 + (bus.isQ ? SQ13 : 13'sd0);
    ply_bot = 13'(bus.yPlayer) + PY13;
    col_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      xn[i]       = 13'(x_q[i]) - STEP13;
      col[i]      = (state[i] == FLY)
                    && (xn[i] - BX13 < ply_r) && (xn[i] + BX13 > ply_l)
                    && (13'(y_q[i]) + BY13 >= ply_top)
                    && (13'(y_q[i]) - BY13 <= ply_bot);
      off_left[i] = (xn[i] < BX13);
      col_any     = col_any | col[i];
    end
  end

  // Spawn uses the registered slot states, so a slot freed on this tick is not reused until the next.
  logic               free_any;
  int                 free_idx;
  logic signed [12:0] spawn_x;
  logic               spawn_ok;

  always_comb begin
    free_any = 1'b0;
    free_idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (state[i] == IDLE) begin
        free_any = 1'b1;
        free_idx = i;
      end
    end
    spawn_x = 13'(bus.xEnemy) - PX13 - BX13;
    if (spawn_x > SPAWN_MAX) spawn_x = SPAWN_MAX;
    spawn_ok = bus.attack && (cnt == '0) && free_any && (spawn_x >= BX13);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= IDLE;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
      cnt     <= '0;
      hit_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      hit_q   <= 1'b0;
      block_q <= 1'b0;
      if (bus.tick) begin
        for (int i = 0; i < N; i++) begin
          if (state[i] == FLY) begin
            // Collision wins over leaving the screen on the same tick.
            if (col[i] || off_left[i]) state[i] <= IDLE;
            else                       x_q[i]   <= 11'(xn[i]);
          end else if (spawn_ok && (i == free_idx)) begin
            state[i] <= FLY;
            x_q[i]   <= 11'(spawn_x);
            y_q[i]   <= bus.yEnemy;
          end
        end
        if (spawn_ok)        cnt <= CW'(COOLDOWN);
        else if (cnt != '0)  cnt <= cnt - CW'(1);
        hit_q   <= col_any & ~bus.defend;
        block_q <= col_any &  bus.defend;
      end
    end
  end

  always_comb begin
    bus.bx     = '0;
    bus.by     = '0;
    bus.bvalid = '0;
    for (int i = 0; i < N; i++) begin
      bus.bx[11*i +: 11] = x_q[i];
      bus.by[10*i +: 10] = y_q[i];
      bus.bvalid[i]      = (state[i] == FLY);
    end
    bus.isHit   = hit_q;
    bus.isBlock = block_q;
  end

endmodule

// File: tb/tb_evil_bullet_pool.sv
// Directed bench for evil_bullet_pool: spawn, motion, hit/block, fly-off, cooldown, pool-full, reset.
module tb_evil_bullet_pool;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  evil_bullet_pool_if #(.N(N)) bus ();

  evil_bullet_pool #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bx_of(input int i);
    logic signed [10:0] v;
    v = bus.bx[11*i +: 11];
    return int'(v);
  endfunction

  function automatic int by_of(input int i);
    logic signed [9:0] v;
    v = bus.by[10*i +: 10];
    return int'(v);
  endfunction

  task automatic step(input logic t);
    @(negedge clk);
    bus.tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setup(input int ye, input logic q, input logic d);
    bus.attack  = 1'b0;
    bus.xEnemy  = 11'sd500;
    bus.yEnemy  = 10'(ye);
    bus.xPlayer = 11'sd100;
    bus.yPlayer = 10'sd300;
    bus.isQ     = q;
    bus.defend  = d;
  endtask

  // Spawn one bullet at tick 0, then run move ticks 1..limit, logging pulses and the free tick.
  task automatic single_run(input int limit, output int hits, output int hit_at,
                            output int blocks, output int block_at, output int free_at);
    hits = 0; hit_at = -1; blocks = 0; block_at = -1; free_at = -1;
    bus.attack = 1'b1;
    step(1'b1);
    bus.attack = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      step(1'b1);
      if (bus.isHit)   begin hits++;   hit_at   = k; end
      if (bus.isBlock) begin blocks++; block_at = k; end
      if (!bus.bvalid[0] && free_at < 0) free_at = k;
    end
  endtask

  int hits, hit_at, blocks, block_at, free_at;
  int first_spawn [N];
  int respawn0;
  int full_at64;
  int pulses;
  logic [N-1:0] prev_v;

  initial begin
    bus.tick = 1'b0;
    setup(300, 1'b0, 1'b0);
    do_reset();
    #1;
    check("rst_bvalid", int'(bus.bvalid), 0);
    check("rst_bx", int'(bus.bx), 0);
    check("rst_by", int'(bus.by), 0);
    check("rst_isHit", int'(bus.isHit), 0);
    check("rst_isBlock", int'(bus.isBlock), 0);

    // Spawn position, first move, no motion on a non-tick cycle
    bus.attack = 1'b1;
    step(1'b1);
    bus.attack = 1'b0;
    check("t1_bvalid", int'(bus.bvalid), 1);
    check("t1_bx0", bx_of(0), 480);
    check("t1_by0", by_of(0), 300);
    step(1'b1);
    check("t1_move_bx0", bx_of(0), 476);
    step(1'b0);
    check("t1_notick_bx0", bx_of(0), 476);

    // Undefended hit
    do_reset();
    setup(300, 1'b0, 1'b0);
    single_run(100, hits, hit_at, blocks, block_at, free_at);
    check("t2_hits", hits, 1);
    check("t2_hit_at", hit_at, 91);
    check("t2_blocks", blocks, 0);
    check("t2_bvalid", int'(bus.bvalid), 0);

    // Defended block
    do_reset();
    setup(300, 1'b0, 1'b1);
    single_run(100, hits, hit_at, blocks, block_at, free_at);
    check("t3_blocks", blocks, 1);
    check("t3_block_at", block_at, 91);
    check("t3_hits", hits, 0);

    // Squatting player dodges; bullet exits left
    do_reset();
    setup(280, 1'b1, 1'b0);
    single_run(125, hits, hit_at, blocks, block_at, free_at);
    check("t4q_pulses", hits + blocks, 0);
    check("t4q_free_at", free_at, 120);

    do_reset();
    setup(280, 1'b0, 1'b0);
    single_run(100, hits, hit_at, blocks, block_at, free_at);
    check("t4s_hit_at", hit_at, 91);
    check("t4s_hits", hits, 1);

    // Cooldown, pool full, respawn into freed slot
    do_reset();
    setup(280, 1'b1, 1'b0);
    bus.attack = 1'b1;
    for (int i = 0; i < N; i++) first_spawn[i] = -1;
    respawn0 = -1; full_at64 = -1; pulses = 0;
    prev_v = '0;
    for (int t = 0; t <= 125; t++) begin
      step(1'b1);
      for (int i = 0; i < N; i++) begin
        if (bus.bvalid[i] && !prev_v[i]) begin
          if (first_spawn[i] < 0) first_spawn[i] = t;
          else if (i == 0 && respawn0 < 0) respawn0 = t;
        end
      end
      if (t == 64) full_at64 = int'(bus.bvalid);
      if (bus.isHit || bus.isBlock) pulses++;
      prev_v = bus.bvalid;
    end
    bus.attack = 1'b0;
    check("t5_spawn0", first_spawn[0], 0);
    check("t5_spawn1", first_spawn[1], 16);
    check("t5_spawn2", first_spawn[2], 32);
    check("t5_spawn3", first_spawn[3], 48);
    check("t5_full64", full_at64, 15);
    check("t5_respawn0", respawn0, 121);
    check("t5_pulses", pulses, 0);

    // Reset mid-flight clears bullets and cooldown
    do_reset();
    setup(280, 1'b1, 1'b0);
    bus.attack = 1'b1;
    for (int t = 0; t <= 20; t++) step(1'b1);
    bus.attack = 1'b0;
    check("t6_two_bullets", int'(bus.bvalid), 3);
    do_reset();
    #1;
    check("t6_rst_bvalid", int'(bus.bvalid), 0);
    check("t6_rst_pulse", int'(bus.isHit) + int'(bus.isBlock), 0);
    bus.attack = 1'b1;
    step(1'b1);
    bus.attack = 1'b0;
    check("t6_respawn", int'(bus.bvalid), 1);

    // Spawn clamp at the left edge
    do_reset();
    setup(300, 1'b0, 1'b0);
    bus.xEnemy = 11'sd23;
    bus.attack = 1'b1;
    step(1'b1);
    check("edge_nospawn", int'(bus.bvalid), 0);
    bus.xEnemy = 11'sd24;
    step(1'b1);
    bus.attack = 1'b0;
    check("edge_spawn", int'(bus.bvalid), 1);
    check("edge_bx0", bx_of(0), 4);
    step(1'b1);
    check("edge_offleft", int'(bus.bvalid), 0);
    check("edge_silent", int'(bus.isHit) + int'(bus.isBlock), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
